qvga_fb_reader: RTL and testbench
=================================

// Module: qvga_fb_reader
// PURPOSE
// - Upstream feeder of the image-filter stage: fetches RGB444 pixels from the 160x120 double-buffered
//   camera frame buffer and upscales them 2x into the VGA bottom-right quadrant (x>=320, y>=240).
// - Delays DE/x/y so they stay cycle-aligned with the returned pixel; outputs drive the filter's
//   DE/x_pixel/y_pixel/r_in/g_in/b_in directly.
// - Owns the read-bank select; swaps banks only at frame start, after the camera writer reports a completed frame.
// PARAMETERS
// - IMG_WIDTH    160  source image width (pixels)
// - IMG_HEIGHT   120  source image height (lines)
// - ORIGIN_X     320  VGA x of window top-left
// - ORIGIN_Y     240  VGA y of window top-left
// - RD_LATENCY   1    frame-buffer read latency (cycles, >=1)
// - PIX_AW       15   pixel-index width (IMG_WIDTH*IMG_HEIGHT <= 2**PIX_AW)
// PORTS
// - clk            in   1         pixel clock
// - reset          in   1         asynchronous, active-low reset
// - DE_in          in   1         VGA display enable
// - x_pixel_in     in   10        VGA x counter
// - y_pixel_in     in   10        VGA y counter
// - wr_frame_done  in   1         1-cycle pulse: writer finished a frame in bank ~rd_bank
// - fb_rd_en       out  1         frame-buffer read strobe
// - fb_rd_addr     out  PIX_AW+1  {rd_bank, pixel index}
// - fb_rd_data     in   12        {R,G,B} 4b each, valid RD_LATENCY cycles after fb_rd_en
// - rd_bank        out  1         bank currently displayed; writer uses ~rd_bank
// - DE_out         out  1         DE_in delayed, aligned with r/g/b_out
// - x_pixel_out    out  10        x_pixel_in delayed, aligned
// - y_pixel_out    out  10        y_pixel_in delayed, aligned
// - r_out, g_out, b_out  out  4 each  pixel; 0 outside window or when DE is low
// BEHAVIOUR
// - Reset (reset=0): all outputs 0; rd_bank=0, swap_pending=0, col/row/phase counters 0.
// - Window hit: DE_in && x in [ORIGIN_X, ORIGIN_X+2*IMG_WIDTH) && y in [ORIGIN_Y, ORIGIN_Y+2*IMG_HEIGHT).
// - Addressing (stage 0, registered, no multiplier):
//   - At x==ORIGIN_X inside the window: col_idx=0, x_phase=0; x_phase toggles every hit cycle;
//     col_idx += 1 after each odd phase.
//   - Pixel index = line_base + col_idx. line_base = 0 on the first window cycle of y==ORIGIN_Y.
//   - At the end of each odd window line (y-ORIGIN_Y odd), line_base += IMG_WIDTH; each source
//     line is therefore read on two VGA lines.
//   - fb_rd_en = registered window hit; fb_rd_addr = {rd_bank, index}. Index never exceeds
//     IMG_WIDTH*IMG_HEIGHT-1; saturate if reached outside a reinit.
// - Latency: DE/x/y/pixel outputs lag the inputs by exactly 1+RD_LATENCY cycles
//   (2 with default). Output rgb = fb_rd_data when the delayed hit flag is 1, else 0.
// - Bank swap:
//   - wr_frame_done sets swap_pending.
//   - frame_start = first cycle with x_pixel_in==0 && y_pixel_in==0.
//   - At frame_start, if swap_pending, or wr_frame_done is high that same cycle: rd_bank toggles
//     and swap_pending clears.
//   - rd_bank never changes at any other time, so no tearing.
//   - A second wr_frame_done before frame_start is absorbed; one swap only.
// - Reset mid-frame: line_base restarts at 0 until the next window top. Addresses stay in range.
//   The first full frame after reset is correct.
// - No back-pressure: the frame buffer must accept a read every cycle.
// STRUCTURE
// - vga_pkg (shared):
//   - constants H_ACTIVE=640, V_ACTIVE=480
//   - typedef rgb444_t {logic[3:0] r,g,b}
//   - typedef vga_pos_t {logic de; logic[9:0] x,y}
// - Sub-module sig_delay #(WIDTH, DEPTH): reset-to-0 shift register.
//   - Used for the {DE,x,y,hit} alignment path (DEPTH = 1+RD_LATENCY).
// TESTING
// - Reset release, sweep one full 800x525 frame with a BRAM model (pattern = index):
//   - (x=320,y=240) -> addr 0; (321,240) -> 0; (322,240) -> 1
//   - (320,241) -> 0; (320,242) -> 160; (639,479) -> 19199
// - Alignment: DE_in high at x=320,y=240 -> DE_out=1, x_pixel_out=320 and rgb=mem[0],
//   all exactly 2 cycles later.
// - Outside window: x=100,y=300 or DE_in=0 -> fb_rd_en=0, rgb_out=0.
// - Swap: pulse wr_frame_done mid-frame -> rd_bank unchanged until frame_start, then 1;
//   addr MSB=1 for the whole next frame.
// - Simultaneous: wr_frame_done at the frame_start cycle -> swap that frame.
//   - Two pulses in one frame -> a single toggle.
// - Async reset asserted at (400,300) mid-frame:
//   - outputs 0 immediately; rd_bank=0
//   - after release, the next frame's addresses match the first test.

Source files
------------

// File: rtl/qvga_fb_reader_pkg.sv
// Shared VGA types and constants for the QVGA frame-buffer reader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qvga_fb_reader_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
    } vga_pos_t;

    // Word carried down the alignment delay line: the raw window hit plus the
    // VGA position it belongs to.
    typedef struct packed {
        logic     hit;
        vga_pos_t pos;
    } align_t;

endpackage

// File: rtl/qvga_fb_reader_if.sv
// Frame-buffer read port: the reader (master) issues a strobe and address every cycle.
// Latency: data returns a fixed number of cycles after fb_rd_en, set by the memory.
// Backpressure: none; the memory must accept one read per cycle.
// Ports: fb_rd_en / fb_rd_addr {bank, pixel index} from the master, fb_rd_data {R,G,B} from the slave.
interface qvga_fb_reader_if #(
    parameter int PIX_AW = 15
);
    logic              fb_rd_en;
    logic [PIX_AW:0]   fb_rd_addr;
    logic [11:0]       fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
    modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/qvga_fb_reader_sig_delay.sv
// Fixed-depth shift register that clears to zero on reset.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle.
// Ports: clk, reset (async active-low), d in, q out (WIDTH bits each).
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/qvga_fb_reader.sv
// Reads the 160x120 RGB444 camera buffer and upscales it 2x into the VGA bottom-right quadrant.
// Latency: DE/x/y/rgb outputs lag the VGA inputs by 1+RD_LATENCY cycles.
// Backpressure: none; one frame-buffer read per window pixel, every cycle.
// Ports: clk, reset (async active-low), VGA timing in, wr_frame_done pulse, fb read master port,
//        rd_bank, aligned DE/x/y out and r/g/b out (zero outside the window).
module qvga_fb_reader
    import qvga_fb_reader_pkg::*;
#(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int ORIGIN_X   = 320,
    parameter int ORIGIN_Y   = 240,
    parameter int RD_LATENCY = 1,
    parameter int PIX_AW     = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    DE_in,
    input  logic [9:0]              x_pixel_in,
    input  logic [9:0]              y_pixel_in,
    input  logic                    wr_frame_done,
    qvga_fb_reader_if.master        fb,
    output logic                    rd_bank,
    output logic                    DE_out,
    output logic [9:0]              x_pixel_out,
    output logic [9:0]              y_pixel_out,
    output logic [3:0]              r_out,
    output logic [3:0]              g_out,
    output logic [3:0]              b_out
);

    localparam logic [9:0]        X_LO    = 10'(ORIGIN_X);
    localparam logic [9:0]        X_LAST  = 10'(ORIGIN_X + 2*IMG_WIDTH - 1);
    localparam logic [9:0]        Y_LO    = 10'(ORIGIN_Y);
    localparam logic [9:0]        Y_LAST  = 10'(ORIGIN_Y + 2*IMG_HEIGHT - 1);
    localparam logic [PIX_AW-1:0] IDX_MAX = PIX_AW'(IMG_WIDTH*IMG_HEIGHT - 1);
    localparam logic [PIX_AW-1:0] STRIDE  = PIX_AW'(IMG_WIDTH);

    // ---------------- window detect and address generation ----------------
    logic              win_hit, line_first, line_last, y_odd;
    logic              x_phase, cur_phase;
    logic [PIX_AW-1:0] col_idx, cur_col;
    logic [PIX_AW-1:0] line_base, cur_base, base_next, pix_idx;
    logic [PIX_AW:0]   idx_sum, base_sum;

    assign win_hit    = DE_in && (x_pixel_in >= X_LO) && (x_pixel_in <= X_LAST)
                              && (y_pixel_in >= Y_LO) && (y_pixel_in <= Y_LAST);
    assign line_first = (x_pixel_in == X_LO);
    assign line_last  = (x_pixel_in == X_LAST);
    assign y_odd      = y_pixel_in[0] ^ Y_LO[0];

    // The first window pixel of a line restarts the column walk; the first pixel
    // of the window's top line also restarts the line base, which is how a
    // mid-frame reset recovers on the next frame.
    assign cur_phase  = line_first ? 1'b0 : x_phase;
    assign cur_col    = line_first ? '0   : col_idx;
    assign cur_base   = (line_first && (y_pixel_in == Y_LO)) ? '0 : line_base;

    assign idx_sum    = {1'b0, cur_base} + {1'b0, cur_col};
    assign pix_idx    = (idx_sum > {1'b0, IDX_MAX}) ? IDX_MAX : idx_sum[PIX_AW-1:0];
    assign base_sum   = {1'b0, cur_base} + {1'b0, STRIDE};
    assign base_next  = (base_sum > {1'b0, IDX_MAX}) ? IDX_MAX : base_sum[PIX_AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_phase       <= 1'b0;
            col_idx       <= '0;
            line_base     <= '0;
            fb.fb_rd_en   <= 1'b0;
            fb.fb_rd_addr <= '0;
        end else begin
            fb.fb_rd_en   <= win_hit;
            fb.fb_rd_addr <= {rd_bank, pix_idx};
            if (win_hit) begin
                x_phase <= ~cur_phase;
                col_idx <= cur_phase ? cur_col + PIX_AW'(1) : cur_col;
                // Each source line is shown on two VGA lines; advance after the second.
                line_base <= (line_last && y_odd) ? base_next : cur_base;
            end
        end
    end

    // ---------------- read-bank ownership ----------------
    logic at_origin, at_origin_q, frame_start, swap_pending;

    assign at_origin   = (x_pixel_in == 10'd0) && (y_pixel_in == 10'd0);
    assign frame_start = at_origin && !at_origin_q;

    // The bank only flips at frame start, so a displayed frame never mixes banks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            at_origin_q  <= 1'b0;
            rd_bank      <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
            if (frame_start && (swap_pending || wr_frame_done)) begin
                rd_bank      <= ~rd_bank;
                swap_pending <= 1'b0;
            end else if (wr_frame_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // ---------------- alignment with returned pixel ----------------
    align_t                     dly_in, dly_out;
    logic [$bits(align_t)-1:0]  dly_q;
    rgb444_t                    pix;

    always_comb begin
        dly_in        = '0;
        dly_in.hit    = win_hit;
        dly_in.pos.de = DE_in;
        dly_in.pos.x  = x_pixel_in;
        dly_in.pos.y  = y_pixel_in;
    end

    sig_delay #(
        .WIDTH ($bits(align_t)),
        .DEPTH (1 + RD_LATENCY)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .d     (dly_in),
        .q     (dly_q)
    );

    assign dly_out     = align_t'(dly_q);
    assign pix         = dly_out.hit ? rgb444_t'(fb.fb_rd_data) : '0;
    assign DE_out      = dly_out.pos.de;
    assign x_pixel_out = dly_out.pos.x;
    assign y_pixel_out = dly_out.pos.y;
    assign r_out       = pix.r;
    assign g_out       = pix.g;
    assign b_out       = pix.b;

endmodule

// File: tb/tb_qvga_fb_reader.sv
// Directed bench for qvga_fb_reader: compressed frames, bank swaps, mid-frame reset.
// Latency: expects addr 1 cycle and DE/x/y/rgb 2 cycles after the inputs.
// Backpressure: none; the memory model answers every read one cycle later.
module tb_qvga_fb_reader;

    logic       clk;
    logic       reset;
    logic       DE_in;
    logic [9:0] x_pixel_in, y_pixel_in;
    logic       wr_frame_done;
    logic       rd_bank, DE_out;
    logic [9:0] x_pixel_out, y_pixel_out;
    logic [3:0] r_out, g_out, b_out;

    qvga_fb_reader_if #(.PIX_AW(15)) fb ();

    qvga_fb_reader dut (
        .clk           (clk),
        .reset         (reset),
        .DE_in         (DE_in),
        .x_pixel_in    (x_pixel_in),
        .y_pixel_in    (y_pixel_in),
        .wr_frame_done (wr_frame_done),
        .fb            (fb),
        .rd_bank       (rd_bank),
        .DE_out        (DE_out),
        .x_pixel_out   (x_pixel_out),
        .y_pixel_out   (y_pixel_out),
        .r_out         (r_out),
        .g_out         (g_out),
        .b_out         (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model, latency 1, contents = low 12 bits of the address.
    always @(posedge clk) begin
        if (fb.fb_rd_en) fb.fb_rd_data <= fb.fb_rd_addr[11:0];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected-state of the bench.
    bit exp_bank, pend, prev_origin, addr_ok;
    bit h1_v, h1_hit, h1_chk, h1_de;
    bit h2_v, h2_hit, h2_chk, h2_de;
    int h1_x, h1_y, h2_x, h2_y;

    function automatic int exp_idx(input int x, input int y);
        return ((y - 240) / 2) * 160 + (x - 320) / 2;
    endfunction

    // Apply one VGA position; first check what the previous two positions produced.
    task automatic step(input int x, input int y, input bit de, input bit wfd);
        bit hit, fs;
        int e;
        @(negedge clk);
        chk("rd_bank", rd_bank, exp_bank);
        if (h1_v) begin
            chk($sformatf("rd_en(%0d,%0d)", h1_x, h1_y), fb.fb_rd_en, h1_hit);
            if (h1_hit)
                chk($sformatf("idx_range(%0d,%0d)", h1_x, h1_y), fb.fb_rd_addr[14:0] <= 15'd19199, 1);
            if (h1_chk) begin
                e = (int'(exp_bank) << 15) + exp_idx(h1_x, h1_y);
                chk($sformatf("addr(%0d,%0d)", h1_x, h1_y), fb.fb_rd_addr, e);
            end
        end
        if (h2_v) begin
            chk($sformatf("de_out(%0d,%0d)", h2_x, h2_y), DE_out, h2_de);
            chk($sformatf("x_out(%0d,%0d)", h2_x, h2_y), x_pixel_out, h2_x);
            chk($sformatf("y_out(%0d,%0d)", h2_x, h2_y), y_pixel_out, h2_y);
            if (!h2_hit)
                chk($sformatf("rgb_zero(%0d,%0d)", h2_x, h2_y), {r_out, g_out, b_out}, 0);
            else if (h2_chk)
                chk($sformatf("rgb(%0d,%0d)", h2_x, h2_y), {r_out, g_out, b_out},
                    exp_idx(h2_x, h2_y) & 32'hFFF);
        end
        hit = de && x >= 320 && x < 640 && y >= 240 && y < 480;
        if (hit && x == 320 && y == 240) addr_ok = 1'b1;
        h2_v = h1_v; h2_hit = h1_hit; h2_chk = h1_chk; h2_de = h1_de; h2_x = h1_x; h2_y = h1_y;
        h1_v = 1'b1; h1_hit = hit; h1_de = de; h1_x = x; h1_y = y;
        h1_chk = hit && addr_ok && (x <= 323 || y == 479);
        fs = (x == 0 && y == 0) && !prev_origin;
        prev_origin = (x == 0 && y == 0);
        if (fs && (pend || wfd)) begin
            exp_bank = ~exp_bank;
            pend = 1'b0;
        end else if (wfd) begin
            pend = 1'b1;
        end
        DE_in = de;
        x_pixel_in = 10'(x);
        y_pixel_in = 10'(y);
        wr_frame_done = wfd;
    endtask

    task automatic reset_model();
        h1_v = 1'b0; h2_v = 1'b0;
        exp_bank = 1'b0; pend = 1'b0; prev_origin = 1'b0; addr_ok = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_de"}, DE_out, 0);
        chk({tag, "_x"}, x_pixel_out, 0);
        chk({tag, "_y"}, y_pixel_out, 0);
        chk({tag, "_rgb"}, {r_out, g_out, b_out}, 0);
        chk({tag, "_rd_en"}, fb.fb_rd_en, 0);
        chk({tag, "_addr"}, fb.fb_rd_addr, 0);
        chk({tag, "_bank"}, rd_bank, 0);
    endtask

    // Asynchronous reset inside the window, while the clock is low.
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1 check_all_zero("midrst");
        reset_model();
        DE_in = 1'b0; x_pixel_in = 10'd700; y_pixel_in = 10'd300; wr_frame_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Compressed frame: every window line gets x=320..323 and x=639; line 479 is swept fully.
    task automatic frame(input bit wfd_start, input int wfd_y1, input int wfd_y2, input bit do_rst);
        step(0, 0, 0, wfd_start);
        step(1, 0, 0, 0);
        step(50, 100, 1, 0);
        for (int y = 240; y < 480; y++) begin
            if (y == 300) step(100, 300, 1, 0);
            for (int x = 320; x <= 323; x++) step(x, y, 1, 0);
            if (y == 300) begin
                step(400, 300, 0, 0);
                step(400, 300, 1, 0);
                if (do_rst) mid_reset();
            end
            if (y == 479) begin
                for (int x = 324; x <= 639; x++) step(x, y, 1, 0);
            end else begin
                step(639, y, 1, 0);
            end
            step(700, y, 0, (y == wfd_y1) || (y == wfd_y2));
        end
        step(700, 500, 0, 0);
        step(700, 524, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        DE_in = 1'b0; x_pixel_in = 10'd700; y_pixel_in = 10'd500; wr_frame_done = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        frame(0, -1, -1, 0);            // bank 0 reference frame
        chk("bank_frame1", rd_bank, 0);
        frame(0, 300, -1, 0);           // pulse mid-frame: no swap yet
        chk("bank_hold", rd_bank, 0);
        frame(0, -1, -1, 0);            // swap at start, whole frame on bank 1
        chk("bank_swapped", rd_bank, 1);
        frame(1, -1, -1, 0);            // pulse on the frame_start cycle itself
        chk("bank_simul", rd_bank, 0);
        frame(0, 260, 400, 0);          // two pulses in one frame
        chk("bank_two_pulse_hold", rd_bank, 0);
        frame(0, -1, -1, 0);            // single toggle
        chk("bank_two_pulse", rd_bank, 1);
        frame(0, -1, -1, 1);            // reset at (400,300)
        chk("bank_after_rst", rd_bank, 0);
        frame(0, -1, -1, 0);            // first full frame after reset
        chk("bank_post_rst", rd_bank, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
